maxnet_serial: RTL and testbench

Parametrised N-channel MAXNET winner-take-all engine: the fixed four-input successor, generalised to N channels, W-bit fixed-point data, an iteration cap, argmax index, and tie/timeout reporting. A single time-multiplexed multiply/subtract datapath processes one channel per cycle. It sits behind the feature-scoring stage and returns the winning channel's original value and index.

---
 rtl/maxnet_serial_if.sv | 28 ++
 rtl/maxnet_serial.sv | 224 ++++++++++++++++++++++
 tb/tb_maxnet_serial.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxnet_serial_if.sv
// Request/result bundle for the serial MAXNET engine.
// master = requester (drives start/in_vec/epsilon), slave = engine.
interface maxnet_serial_if #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int MAX_ITER = 64
) ();
  logic                             start;
  logic [N*W-1:0]                   in_vec;
  logic [W-1:0]                     epsilon;
  logic                             busy;
  logic                             done;
  logic [W-1:0]                     max_val;
  logic [$clog2(N)-1:0]             max_idx;
  logic                             tie;
  logic                             timeout;
  logic [$clog2(MAX_ITER+1)-1:0]    iters;

  modport master (
    output start, in_vec, epsilon,
    input  busy, done, max_val, max_idx, tie, timeout, iters
  );

  modport slave (
    input  start, in_vec, epsilon,
    output busy, done, max_val, max_idx, tie, timeout, iters
  );
endinterface

// File: rtl/maxnet_serial.sv
// Serial N-channel MAXNET winner-take-all engine.
// One channel per cycle: SCAN accumulates sum/count/argmax, DECIDE picks
// finish or another iteration, UPDATE applies lateral inhibition in place.
module maxnet_serial #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 64
) (
  input logic             clk,
  input logic             rst,
  maxnet_serial_if.slave  bus
);

  localparam int IW  = $clog2(N);
  localparam int SW  = W + IW;            // running sum width
  localparam int PW  = W + SW;            // epsilon * (S - x) product width
  localparam int CW  = $clog2(N + 1);     // nonzero-channel count width
  localparam int ITW = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, UPDATE, DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   ch_reg;
  logic [W-1:0]    x_reg    [N];
  logic [W-1:0]    orig_reg [N];
  logic [W-1:0]    eps_reg;
  logic [ITW-1:0]  iter_reg;
  logic [N-1:0]    prev_mask_reg;
  logic [N-1:0]    mask_reg;
  logic [SW-1:0]   sum_reg;
  logic [CW-1:0]   count_reg;
  logic [W-1:0]    best_val_reg;
  logic [IW-1:0]   best_idx_reg;
  logic            tie_scan_reg;

  logic            busy_reg;
  logic            done_reg;
  logic [W-1:0]    max_val_reg;
  logic [IW-1:0]   max_idx_reg;
  logic            tie_reg;
  logic            timeout_reg;
  logic [ITW-1:0]  iters_reg;

  // Unpack the flat channel bus into per-channel words.
  logic [W-1:0] in_ch [N];
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign in_ch[gi] = bus.in_vec[gi*W +: W];
    end
  endgenerate

  // Shared inhibition datapath for the channel currently addressed.
  // S is frozen during UPDATE, so S - x never underflows and the
  // subtraction of inhib saturates at zero.
  logic [W-1:0]  x_cur;
  logic [SW-1:0] diff;
  logic [PW-1:0] prod;
  logic [PW-1:0] inhib;
  logic [W-1:0]  x_upd;

  assign x_cur = x_reg[ch_reg];

  // Compute the updated value of the addressed channel.
  always_comb begin
    diff  = sum_reg - SW'(x_cur);
    prod  = PW'(eps_reg) * PW'(diff);
    inhib = prod >> FRAC;
    x_upd = (PW'(x_cur) > inhib) ? (x_cur - inhib[W-1:0]) : '0;
  end

  // Finish decision and result selection evaluated during DECIDE.
  logic [IW-1:0] low_idx;
  logic [IW-1:0] dec_idx;
  logic          dec_tie;
  logic          dec_timeout;
  logic          dec_finish;

  // Lowest surviving channel of the previous iteration, and the finish rule.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (prev_mask_reg[i]) low_idx = IW'(i);
    end
    dec_finish  = 1'b1;
    dec_idx     = best_idx_reg;
    dec_tie     = tie_scan_reg;
    dec_timeout = 1'b0;
    if (count_reg == CW'(1)) begin
      dec_tie = 1'b0;
    end else if (count_reg == '0) begin
      // Everything was knocked out together: fall back to the last survivors.
      dec_idx = low_idx;
      dec_tie = 1'b1;
    end else if (iter_reg == ITW'(MAX_ITER)) begin
      dec_timeout = 1'b1;
    end else begin
      dec_finish = 1'b0;
    end
  end

  // Control FSM with all state and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      for (int i = 0; i < N; i++) begin
        x_reg[i]    <= '0;
        orig_reg[i] <= '0;
      end
      eps_reg       <= '0;
      iter_reg      <= '0;
      prev_mask_reg <= '0;
      mask_reg      <= '0;
      sum_reg       <= '0;
      count_reg     <= '0;
      best_val_reg  <= '0;
      best_idx_reg  <= '0;
      tie_scan_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      max_val_reg   <= '0;
      max_idx_reg   <= '0;
      tie_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
      iters_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) begin
              x_reg[i]    <= in_ch[i];
              orig_reg[i] <= in_ch[i];
            end
            eps_reg       <= bus.epsilon;
            iter_reg      <= '0;
            prev_mask_reg <= '1;
            mask_reg      <= '0;
            sum_reg       <= '0;
            count_reg     <= '0;
            best_val_reg  <= '0;
            best_idx_reg  <= '0;
            tie_scan_reg  <= 1'b0;
            ch_reg        <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= SCAN;
          end
        end

        SCAN: begin
          sum_reg <= sum_reg + SW'(x_cur);
          if (x_cur != '0) begin
            count_reg        <= count_reg + CW'(1);
            mask_reg[ch_reg] <= 1'b1;
          end
          if (x_cur > best_val_reg) begin
            best_val_reg <= x_cur;
            best_idx_reg <= ch_reg;
            tie_scan_reg <= 1'b0;
          end else if ((x_cur == best_val_reg) && (x_cur != '0)) begin
            tie_scan_reg <= 1'b1;
          end
          if (ch_reg == IW'(N - 1)) begin
            ch_reg    <= '0;
            state_reg <= DECIDE;
          end else begin
            ch_reg <= ch_reg + IW'(1);
          end
        end

        DECIDE: begin
          if (dec_finish) begin
            done_reg    <= 1'b1;
            max_idx_reg <= dec_idx;
            max_val_reg <= orig_reg[dec_idx];
            tie_reg     <= dec_tie;
            timeout_reg <= dec_timeout;
            iters_reg   <= iter_reg;
            state_reg   <= DONE;
          end else begin
            prev_mask_reg <= mask_reg;
            ch_reg        <= '0;
            state_reg     <= UPDATE;
          end
        end

        UPDATE: begin
          x_reg[ch_reg] <= x_upd;
          if (ch_reg == IW'(N - 1)) begin
            iter_reg     <= iter_reg + ITW'(1);
            sum_reg      <= '0;
            count_reg    <= '0;
            mask_reg     <= '0;
            best_val_reg <= '0;
            best_idx_reg <= '0;
            tie_scan_reg <= 1'b0;
            ch_reg       <= '0;
            state_reg    <= SCAN;
          end else begin
            ch_reg <= ch_reg + IW'(1);
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.max_val = max_val_reg;
  assign bus.max_idx = max_idx_reg;
  assign bus.tie     = tie_reg;
  assign bus.timeout = timeout_reg;
  assign bus.iters   = iters_reg;

endmodule

// File: tb/tb_maxnet_serial.sv
// Directed bench for maxnet_serial (N=4, W=16, FRAC=8, MAX_ITER=16).
// Cycle n = the clock period that ends at the n-th edge after the accept
// edge; outputs are sampled on the falling edge inside that period.
module tb_maxnet_serial;

  localparam logic [63:0] V1   = 64'h014D_01B3_019A_0066;
  localparam logic [63:0] V0   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] V3   = 64'h0200_0000_0000_0000;
  localparam logic [63:0] VEQ  = 64'h0100_0100_0100_0100;
  localparam logic [63:0] VTIE = 64'h0000_0300_0300_0080;
  localparam logic [63:0] VKO  = 64'h0050_0050_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   dones;
  int   first_done;
  int   c;
  logic [15:0] cap_val;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_iters;

  maxnet_serial_if #(.N(4), .W(16), .MAX_ITER(16)) bus ();

  maxnet_serial #(.N(4), .W(16), .FRAC(8), .MAX_ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one vector and wait for done; cycle of done returned (-1 on expiry).
  task automatic run(input logic [63:0] vec, input logic [15:0] eps,
                     input int budget, output int done_cyc);
    int n;
    @(negedge clk);
    bus.in_vec  = vec;
    bus.epsilon = eps;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    check("busy_after_accept", bus.busy, 1);
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    done_cyc = bus.done ? n : -1;
  endtask

  task automatic check_result(input string tag, input int got_cyc, input int exp_cyc,
                              input logic [15:0] val, input logic [1:0] idx,
                              input logic tie, input logic tmo, input logic [4:0] it);
    check({tag, "_cycle"},   got_cyc,     exp_cyc);
    check({tag, "_max_val"}, bus.max_val, val);
    check({tag, "_max_idx"}, bus.max_idx, idx);
    check({tag, "_tie"},     bus.tie,     tie);
    check({tag, "_timeout"}, bus.timeout, tmo);
    check({tag, "_iters"},   bus.iters,   it);
    check({tag, "_busy"},    bus.busy,    1);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle"},       bus.busy, 0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.in_vec  = '0;
    bus.epsilon = '0;

    #1;
    check("rst_busy",    bus.busy,    0);
    check("rst_done",    bus.done,    0);
    check("rst_max_val", bus.max_val, 0);
    check("rst_max_idx", bus.max_idx, 0);
    check("rst_tie",     bus.tie,     0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_iters",   bus.iters,   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run(V1, 16'h004D, 200, cyc);
    $display("txn v1: cyc=%0d idx=%0d val=%h iters=%0d", cyc, bus.max_idx, bus.max_val, bus.iters);
    check_result("v1", cyc, 51, 16'h01B3, 2'd2, 1'b0, 1'b0, 5'd5);

    run(V0, 16'h004D, 50, cyc);
    $display("txn zeros: cyc=%0d idx=%0d tie=%0d", cyc, bus.max_idx, bus.tie);
    check_result("zeros", cyc, 6, 16'h0000, 2'd0, 1'b1, 1'b0, 5'd0);

    run(V3, 16'h004D, 50, cyc);
    $display("txn single: cyc=%0d idx=%0d val=%h", cyc, bus.max_idx, bus.max_val);
    check_result("single", cyc, 6, 16'h0200, 2'd3, 1'b0, 1'b0, 5'd0);

    run(VEQ, 16'h0040, 400, cyc);
    $display("txn stall: cyc=%0d timeout=%0d iters=%0d", cyc, bus.timeout, bus.iters);
    check_result("stall", cyc, 150, 16'h0100, 2'd0, 1'b1, 1'b1, 5'd16);

    // epsilon zero never inhibits: equal maxima at ch1/ch2, lowest index wins.
    run(VTIE, 16'h0000, 400, cyc);
    $display("txn tie: cyc=%0d idx=%0d val=%h", cyc, bus.max_idx, bus.max_val);
    check_result("tie", cyc, 150, 16'h0300, 2'd1, 1'b1, 1'b1, 5'd16);

    // Two equal survivors knock each other out in one update.
    run(VKO, 16'h0100, 100, cyc);
    $display("txn knockout: cyc=%0d idx=%0d val=%h", cyc, bus.max_idx, bus.max_val);
    check_result("knockout", cyc, 15, 16'h0050, 2'd2, 1'b1, 1'b0, 5'd1);

    // Reset during the first UPDATE pass of V1.
    @(negedge clk);
    bus.in_vec  = V1;
    bus.epsilon = 16'h004D;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("txn reset_mid_run: busy=%0d idx=%0d val=%h", bus.busy, bus.max_idx, bus.max_val);
    check("mrst_busy",    bus.busy,    0);
    check("mrst_done",    bus.done,    0);
    check("mrst_max_val", bus.max_val, 0);
    check("mrst_max_idx", bus.max_idx, 0);
    check("mrst_tie",     bus.tie,     0);
    check("mrst_iters",   bus.iters,   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mrst_no_done", dones, 0);

    run(V3, 16'h004D, 50, cyc);
    $display("txn after_reset: cyc=%0d idx=%0d val=%h", cyc, bus.max_idx, bus.max_val);
    check_result("after_reset", cyc, 6, 16'h0200, 2'd3, 1'b0, 1'b0, 5'd0);

    // Start pulses at cycles 3 and 20 with a different vector must be ignored.
    @(negedge clk);
    bus.in_vec  = V1;
    bus.epsilon = 16'h004D;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.in_vec = V0;
    dones = 0;
    first_done = -1;
    cap_val = '0;
    cap_idx = '0;
    cap_iters = '0;
    for (int n = 1; n <= 70; n++) begin
      if (n > 1) @(negedge clk);
      bus.start = (n == 3) || (n == 20);
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = n;
          cap_val    = bus.max_val;
          cap_idx    = bus.max_idx;
          cap_iters  = bus.iters;
        end
      end
    end
    bus.start = 1'b0;
    $display("txn ignore_start: dones=%0d cyc=%0d idx=%0d val=%h", dones, first_done, cap_idx, cap_val);
    check("ign_done_count", dones,      1);
    check("ign_cycle",      first_done, 51);
    check("ign_max_val",    cap_val,    16'h01B3);
    check("ign_max_idx",    cap_idx,    2);
    check("ign_iters",      cap_iters,  5);

    // start held high through DONE: re-accepted only from IDLE after done.
    @(negedge clk);
    bus.in_vec  = V3;
    bus.epsilon = 16'h0000;
    bus.start   = 1'b1;
    @(negedge clk);
    c = 1;
    while (!bus.done && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("hold_first_cycle", c, 6);
    bus.in_vec = V0;
    @(negedge clk);
    c++;
    check("hold_idle_busy", bus.busy, 0);
    @(negedge clk);
    c++;
    check("hold_reaccept_busy", bus.busy, 1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    c += 2;
    check("hold_keep_idx", bus.max_idx, 3);
    check("hold_keep_val", bus.max_val, 16'h0200);
    while (!bus.done && c < 30) begin
      @(negedge clk);
      c++;
    end
    $display("txn held_start: second done cyc=%0d idx=%0d tie=%0d", c, bus.max_idx, bus.tie);
    check("hold_second_cycle", c, 13);
    check("hold_second_idx",   bus.max_idx, 0);
    check("hold_second_val",   bus.max_val, 0);
    check("hold_second_tie",   bus.tie,     1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
